dec_mem: RTL and testbench

DEC_MEM -- requirements
Module: dec_mem

---
 rtl/dec_mem.sv | 65 ++++++
 tb/tb_dec_mem.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/dec_mem.sv
// Viterbi decision memory: four rotating TB_LEN x 8 banks. One bank fills while the two
// previous banks are read in descending order for traceback and decode.
module dec_mem #(
  parameter int TB_LEN = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] d_in,
  output logic [7:0] d_o_0,
  output logic [7:0] d_o_1,
  output logic       selection,
  output logic       tb_en
);

  localparam int AW = $clog2(TB_LEN);
  localparam logic [AW-1:0] WA_LAST = AW'(TB_LEN - 1);

  logic [7:0]    mem [4][TB_LEN];
  logic [1:0]    w;
  logic [1:0]    w_m1;
  logic [1:0]    w_m2;
  logic [AW-1:0] wa;
  logic [AW-1:0] ra;
  logic [1:0]    fill;

  // TB_LEN is a power of two, so TB_LEN-1-wa is the bitwise complement of wa.
  assign ra   = ~wa;
  assign w_m1 = w - 2'd1;
  assign w_m2 = w - 2'd2;

  // The write bank is never read, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (!rst && enable) begin
      mem[w][wa] <= d_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w         <= 2'd0;
      wa        <= '0;
      fill      <= 2'd0;
      selection <= 1'b0;
      tb_en     <= 1'b0;
      d_o_0     <= 8'h00;
      d_o_1     <= 8'h00;
    end else if (enable) begin
      d_o_0 <= mem[w_m1][ra];
      d_o_1 <= mem[w_m2][ra];
      tb_en <= (fill == 2'd2);
      if (wa == WA_LAST) begin
        wa        <= '0;
        w         <= w + 2'd1;
        selection <= ~selection;
        if (fill != 2'd2) begin
          fill <= fill + 2'd1;
        end
      end else begin
        wa <= wa + AW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dec_mem.sv
// Directed bench for dec_mem: a write-history model predicts every output cycle, and
// literal checks pin the key sequence points.
module tb_dec_mem;

  localparam int L = 8;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] d_in;
  logic [7:0] d_o_0;
  logic [7:0] d_o_1;
  logic       selection;
  logic       tb_en;

  int checks = 0;
  int errors = 0;

  dec_mem #(.TB_LEN(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .d_in      (d_in),
    .d_o_0     (d_o_0),
    .d_o_1     (d_o_1),
    .selection (selection),
    .tb_en     (tb_en)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: history of words written since the last reset ----------------
  // Write n (0-based) sits in block n/L at position n%L; its read returns the words of the
  // two preceding blocks at the mirrored position.
  logic [7:0] hist[$];
  int         cnt = 0;
  bit         started = 0;
  bit         exp_known;
  logic [7:0] exp_d0, exp_d1;
  logic       exp_tb;

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      cnt       = 0;
      started   = 1;
      exp_known = 1;
      exp_d0    = 8'h00;
      exp_d1    = 8'h00;
      exp_tb    = 1'b0;
    end else if (enable && started) begin
      int b, p;
      b = cnt / L;
      p = cnt % L;
      exp_tb    = (b >= 2);
      exp_known = (b >= 2);
      if (b >= 2) begin
        exp_d0 = hist[(b - 1) * L + (L - 1 - p)];
        exp_d1 = hist[(b - 2) * L + (L - 1 - p)];
      end
      hist.push_back(d_in);
      cnt++;
    end
  end

  // ---------------- compare process ----------------
  always @(posedge clk) begin
    #1;
    if (started) begin
      chk("selection", {7'd0, selection}, {7'd0, 1'(((cnt / L) % 2))});
      chk("tb_en", {7'd0, tb_en}, {7'd0, exp_tb});
      if (exp_known) begin
        chk("d_o_0", d_o_0, exp_d0);
        chk("d_o_1", d_o_1, exp_d1);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic cyc(input logic r, input logic en, input logic [7:0] d);
    @(negedge clk);
    rst    = r;
    enable = en;
    d_in   = d;
    @(posedge clk);
    #2;
  endtask

  task automatic block(input logic [7:0] base);
    for (int i = 0; i < L; i++) cyc(1'b0, 1'b1, base + 8'(i));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; enable = 1'b0; d_in = 8'h00;
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 8'h00);
    chk("rst_d_o_0", d_o_0, 8'h00);
    chk("rst_d_o_1", d_o_1, 8'h00);
    chk("rst_tb_en", {7'd0, tb_en}, 8'h00);
    chk("rst_sel", {7'd0, selection}, 8'h00);

    block(8'h00);
    chk("a_sel", {7'd0, selection}, 8'h01);
    chk("a_tb_en", {7'd0, tb_en}, 8'h00);
    block(8'h10);
    chk("b_sel", {7'd0, selection}, 8'h00);
    chk("b_tb_en", {7'd0, tb_en}, 8'h00);

    cyc(1'b0, 1'b1, 8'h20);
    chk("c0_d_o_0", d_o_0, 8'h17);
    chk("c0_d_o_1", d_o_1, 8'h07);
    chk("c0_tb_en", {7'd0, tb_en}, 8'h01);
    for (int i = 1; i < 4; i++) cyc(1'b0, 1'b1, 8'h20 + 8'(i));
    chk("c3_d_o_0", d_o_0, 8'h14);
    chk("c3_d_o_1", d_o_1, 8'h04);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'hAA);
      chk("stall_d_o_0", d_o_0, 8'h14);
      chk("stall_d_o_1", d_o_1, 8'h04);
      chk("stall_tb_en", {7'd0, tb_en}, 8'h01);
    end
    cyc(1'b0, 1'b1, 8'h24);
    chk("resume_d_o_0", d_o_0, 8'h13);
    chk("resume_d_o_1", d_o_1, 8'h03);
    for (int i = 5; i < L; i++) cyc(1'b0, 1'b1, 8'h20 + 8'(i));
    chk("c7_d_o_0", d_o_0, 8'h10);
    chk("c7_d_o_1", d_o_1, 8'h00);

    block(8'h30);
    cyc(1'b0, 1'b1, 8'h40);
    chk("blk4_d_o_0", d_o_0, 8'h37);
    chk("blk4_d_o_1", d_o_1, 8'h27);
    for (int i = 1; i < L; i++) cyc(1'b0, 1'b1, 8'h40 + 8'(i));
    chk("blk4_end_d_o_0", d_o_0, 8'h30);
    chk("blk4_end_d_o_1", d_o_1, 8'h20);

    // Reset mid-block with enable high and a junk word that must not be written.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 8'h50 + 8'(i));
    cyc(1'b1, 1'b1, 8'hFF);
    chk("mrst_d_o_0", d_o_0, 8'h00);
    chk("mrst_d_o_1", d_o_1, 8'h00);
    chk("mrst_tb_en", {7'd0, tb_en}, 8'h00);
    chk("mrst_sel", {7'd0, selection}, 8'h00);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 1'b1, 8'h80 + 8'(i));
      if (i < 16) chk("refill_tb_en", {7'd0, tb_en}, 8'h00);
      if (i == 16) begin
        chk("refill17_tb_en", {7'd0, tb_en}, 8'h01);
        chk("refill17_d_o_0", d_o_0, 8'h8F);
        chk("refill17_d_o_1", d_o_1, 8'h87);
      end
    end
    chk("bank0_addr0_d_o_1", d_o_1, 8'h80);
    chk("bank1_addr0_d_o_0", d_o_0, 8'h88);

    cyc(1'b0, 1'b0, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
